// File: rtl/uart_pkg.sv
// Shared types and widths for the UART transmit arbiter.
package uart_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned OWNER_W = 2;
  localparam int unsigned COUNT_W = 16;
  localparam int unsigned DATA_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  // One-hot acknowledge vector for a requester index.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [OWNER_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle of the UART transmit arbiter.
interface uart_tx_arbiter_if;
  import uart_pkg::*;

  logic [NUM_REQ-1:0]        i_req;
  logic [NUM_REQ*DATA_W-1:0] i_data;
  logic [NUM_REQ-1:0]        o_ack;
  logic [DATA_W-1:0]         o_txdata;
  logic                      o_txstart;
  logic                      i_txbusy;

  // Arbiter side.
  modport slave (
    input  i_req,
    input  i_data,
    input  i_txbusy,
    output o_ack,
    output o_txdata,
    output o_txstart
  );

  // Requesters and transmitter side.
  modport master (
    output i_req,
    output i_data,
    output i_txbusy,
    input  o_ack,
    input  o_txdata,
    input  o_txstart
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester at or after (last + 1) mod NUM_REQ.
module rr_arbiter
  import uart_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [OWNER_W-1:0] last,
  output logic [OWNER_W-1:0] grant_c,
  output logic               valid_c
);

  logic [OWNER_W-1:0] idx;

  // Scan the ring starting one past the previous winner; the index wraps naturally.
  always_comb begin
    grant_c = '0;
    valid_c = 1'b0;
    idx     = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = last + OWNER_W'(i);
      if (!valid_c && req[idx]) begin
        grant_c = idx;
        valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among four byte requesters with round-robin
// grants, a start timeout, and an inter-frame gap.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned GAP_CYCLES    = 16,
  parameter int unsigned START_TIMEOUT = 64
) (
  input  logic               i_clk,
  input  logic               i_reset,
  uart_tx_arbiter_if.slave   bus,
  output logic [OWNER_W-1:0] o_owner,
  output logic               o_err,
  input  logic               i_errclr,
  output logic [COUNT_W-1:0] o_txcount
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned TO_W  = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(START_TIMEOUT - 1);
  // With no gap configured a finished or abandoned frame returns straight to IDLE.
  localparam state_e POST_FRAME = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

  state_e               state_q, state_d;
  logic                 txstart_q, txstart_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [DATA_W-1:0]    txdata_q, txdata_d;
  logic [OWNER_W-1:0]   owner_q, owner_d;
  logic [OWNER_W-1:0]   last_q, last_d;
  logic                 err_q, err_d;
  logic [COUNT_W-1:0]   txcount_q, txcount_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;

  logic [OWNER_W-1:0]   grant_idx_c;
  logic                 grant_valid_c;

  rr_arbiter u_rr (
    .req     (bus.i_req),
    .last    (last_q),
    .grant_c (grant_idx_c),
    .valid_c (grant_valid_c)
  );

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    txstart_d = txstart_q;
    ack_d     = '0;
    txdata_d  = txdata_q;
    owner_d   = owner_q;
    last_d    = last_q;
    err_d     = err_q;
    txcount_d = txcount_q;
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;

    // Clear first so a timeout in the same cycle wins.
    if (i_errclr) begin
      err_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (grant_valid_c) begin
          state_d   = ST_START;
          txstart_d = 1'b1;
          ack_d     = onehot(grant_idx_c);
          txdata_d  = bus.i_data[{grant_idx_c, 3'b000} +: DATA_W];
          owner_d   = grant_idx_c;
          last_d    = grant_idx_c;
          to_cnt_d  = '0;
        end
      end
      ST_START: begin
        if (bus.i_txbusy) begin
          state_d   = ST_BUSY;
          txstart_d = 1'b0;
        end else if (to_cnt_q == TO_LAST) begin
          state_d   = POST_FRAME;
          txstart_d = 1'b0;
          err_d     = 1'b1;
          gap_cnt_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_BUSY: begin
        if (!bus.i_txbusy) begin
          state_d   = POST_FRAME;
          txcount_d = txcount_q + COUNT_W'(1);
          gap_cnt_d = '0;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = ST_IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      txstart_q <= 1'b0;
      ack_q     <= '0;
      txdata_q  <= '0;
      owner_q   <= '0;
      last_q    <= OWNER_W'(NUM_REQ - 1);
      err_q     <= 1'b0;
      txcount_q <= '0;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      txstart_q <= txstart_d;
      ack_q     <= ack_d;
      txdata_q  <= txdata_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      err_q     <= err_d;
      txcount_q <= txcount_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign bus.o_ack     = ack_q;
  assign bus.o_txdata  = txdata_q;
  assign bus.o_txstart = txstart_q;
  assign o_owner       = owner_q;
  assign o_err         = err_q;
  assign o_txcount     = txcount_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with GAP_CYCLES=16, START_TIMEOUT=64.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  owner;
  logic        err;
  logic        errclr;
  logic [15:0] cnt;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(
    .GAP_CYCLES    (16),
    .START_TIMEOUT (64)
  ) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .bus       (bus),
    .o_owner   (owner),
    .o_err     (err),
    .i_errclr  (errclr),
    .o_txcount (cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for o_txstart to rise; leaves us at the negedge where it is seen.
  task automatic wait_start(output int n);
    n = 0;
    while (bus.o_txstart !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("start_seen", 32'(bus.o_txstart), 32'd1);
  endtask

  // From a START cycle: busy one cycle, then drop; returns in the first post-frame cycle.
  task automatic finish_frame();
    bus.i_txbusy = 1'b1;
    @(negedge clk);
    bus.i_txbusy = 1'b0;
    @(negedge clk);
  endtask

  int n;
  int exp_owner[5] = '{0, 1, 2, 3, 0};
  logic [31:0] data_word;

  initial begin
    rst          = 1'b1;
    errclr       = 1'b0;
    bus.i_req    = '0;
    bus.i_data   = '0;
    bus.i_txbusy = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst_txstart", 32'(bus.o_txstart), 32'd0);
    chk("rst_ack", 32'(bus.o_ack), 32'd0);
    chk("rst_txdata", 32'(bus.o_txdata), 32'h00);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_count", 32'(cnt), 32'd0);
    rst = 1'b0;

    // Single frame from requester 0, one-cycle grant latency
    bus.i_req  = 4'b0001;
    bus.i_data = 32'h0000_00A5;
    @(negedge clk);
    chk("t1_txstart", 32'(bus.o_txstart), 32'd1);
    chk("t1_ack", 32'(bus.o_ack), 32'h1);
    chk("t1_txdata", 32'(bus.o_txdata), 32'hA5);
    chk("t1_owner", 32'(owner), 32'd0);
    bus.i_req = 4'b0000;
    @(negedge clk);
    chk("t1_ack_pulse", 32'(bus.o_ack), 32'h0);
    chk("t1_txstart_hold", 32'(bus.o_txstart), 32'd1);
    @(negedge clk);
    bus.i_txbusy = 1'b1;
    @(negedge clk);
    chk("t1_txstart_busy", 32'(bus.o_txstart), 32'd0);
    repeat (175) @(negedge clk);
    bus.i_txbusy = 1'b0;
    @(negedge clk);
    chk("t1_count", 32'(cnt), 32'd1);
    // Request during the gap: data must not be taken until IDLE
    bus.i_req  = 4'b0001;
    bus.i_data = 32'h0000_003C;
    repeat (8) @(negedge clk);
    chk("t1_txdata_hold", 32'(bus.o_txdata), 32'hA5);
    chk("t1_gap_nostart", 32'(bus.o_txstart), 32'd0);
    n = 8;
    while (bus.o_txstart !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t1_gap_len", 32'(n), 32'd17);
    chk("t1_txdata2", 32'(bus.o_txdata), 32'h3C);
    bus.i_req = 4'b0000;
    finish_frame();
    chk("t1_count2", 32'(cnt), 32'd2);

    // Round-robin order from reset with all requesters held
    rst = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    bus.i_req  = 4'b1111;
    data_word  = 32'h4433_2211;
    bus.i_data = data_word;
    for (int k = 0; k < 5; k++) begin
      wait_start(n);
      chk("rr_owner", 32'(owner), 32'(exp_owner[k]));
      chk("rr_ack", 32'(bus.o_ack), 32'(onehot(2'(exp_owner[k]))));
      chk("rr_txdata", 32'(bus.o_txdata), 32'(data_word[8*exp_owner[k] +: 8]));
      finish_frame();
    end
    bus.i_req = 4'b0000;
    chk("rr_count", 32'(cnt), 32'd5);

    // Start timeout: txstart high exactly 64 cycles
    bus.i_req = 4'b0001;
    wait_start(n);
    bus.i_req = 4'b0000;
    n = 0;
    while (bus.o_txstart === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("to_len", 32'(n), 32'd64);
    chk("to_err", 32'(err), 32'd1);
    chk("to_count", 32'(cnt), 32'd5);
    errclr = 1'b1;
    @(negedge clk);
    errclr = 1'b0;
    chk("to_errclr", 32'(err), 32'd0);

    // Timeout coinciding with errclr: set wins
    bus.i_req = 4'b0001;
    wait_start(n);
    bus.i_req = 4'b0000;
    n = 0;
    while (bus.o_txstart === 1'b1 && n < 200) begin
      n++;
      if (n == 64) errclr = 1'b1;
      @(negedge clk);
    end
    errclr = 1'b0;
    chk("setwin_len", 32'(n), 32'd64);
    chk("setwin_err", 32'(err), 32'd1);

    // Counter wrap from 0xFFFF
    repeat (20) @(negedge clk);
    force dut.txcount_q = 16'hFFFF;
    @(negedge clk);
    release dut.txcount_q;
    @(negedge clk);
    chk("wrap_pre", 32'(cnt), 32'hFFFF);
    bus.i_req = 4'b0001;
    wait_start(n);
    bus.i_req = 4'b0000;
    finish_frame();
    chk("wrap_count", 32'(cnt), 32'h0000);

    // Reset in BUSY abandons the frame; priority restarts at requester 0
    bus.i_req  = 4'b0001;
    bus.i_data = 32'hBB00_00CC;
    wait_start(n);
    bus.i_req    = 4'b0000;
    bus.i_txbusy = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_txstart", 32'(bus.o_txstart), 32'd0);
    chk("mrst_ack", 32'(bus.o_ack), 32'h0);
    chk("mrst_txdata", 32'(bus.o_txdata), 32'h00);
    chk("mrst_owner", 32'(owner), 32'd0);
    chk("mrst_err", 32'(err), 32'd0);
    chk("mrst_count", 32'(cnt), 32'd0);
    rst          = 1'b0;
    bus.i_txbusy = 1'b0;
    bus.i_req    = 4'b1001;
    @(negedge clk);
    chk("post_txstart", 32'(bus.o_txstart), 32'd1);
    chk("post_owner", 32'(owner), 32'd0);
    chk("post_ack", 32'(bus.o_ack), 32'h1);
    chk("post_txdata", 32'(bus.o_txdata), 32'hCC);
    bus.i_req = 4'b1000;
    finish_frame();
    chk("post_count", 32'(cnt), 32'd1);
    wait_start(n);
    chk("post_owner3", 32'(owner), 32'd3);
    chk("post_txdata3", 32'(bus.o_txdata), 32'hBB);
    bus.i_req = 4'b0000;
    finish_frame();
    chk("post_count2", 32'(cnt), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
